// File: rtl/reduce_tree_if.sv
// Handshake bundle for reduce_tree: the input beat side (valid/ready, mode,
// packed channel words) and the result side (valid/ready, reduced word, busy).
// The slave modport is the reduction block's view, master is the driver's.
interface reduce_tree_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [1:0]                in_mode;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          out_data;
  logic                      busy;

  modport master (
    output in_valid,
    output in_mode,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_mode,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output busy
  );
endinterface

// File: rtl/reduce_tree.sv
// Pipelined bitwise reduction tree. CHANNELS words of WIDTH bits are folded
// pairwise, one register stage per tree level, into a single word using the
// operator selected per beat (AND / OR / XOR, mode 11 aliases AND). Every
// stage carries its own valid flag and mode, so beats with different
// operators can be in flight together. A ready chain gives full throughput
// and lossless backpressure.
//
// Tree layout: all register nodes live in one array node_q, ordered level by
// level (level-1 nodes first, the output node last). The source vector src_s
// places the input words first and the nodes after them, which makes the
// two children of node i simply src_s[2*i] and src_s[2*i+1] at every level.
module reduce_tree #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic          clk,
  input  logic          nreset,
  reduce_tree_if.slave  bus
);

  localparam int LEVELS = $clog2(CHANNELS);
  localparam int NODES  = CHANNELS - 1;
  localparam int SRCS   = 2 * CHANNELS - 2;

  // Apply the beat's operator to one pair of words.
  function automatic logic [WIDTH-1:0] combine(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [1:0]       mode
  );
    logic [WIDTH-1:0] r;
    case (mode)
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // Zero-based tree level (= pipeline stage index) of node idx.
  function automatic int node_level(input int idx);
    int lvl;
    int base;
    lvl  = 0;
    base = 0;
    for (int k = 0; k < LEVELS; k++) begin
      if (idx >= base) begin
        lvl = k;
      end else begin
        lvl = lvl;
      end
      base = base + (CHANNELS >> (k + 1));
    end
    return lvl;
  endfunction

  logic [WIDTH-1:0]       node_q [NODES];
  logic [WIDTH-1:0]       node_d [NODES];
  logic [WIDTH-1:0]       src_s  [SRCS];
  logic [LEVELS-1:0]      v_q;
  logic [LEVELS-1:0]      v_d;
  logic [LEVELS-1:0][1:0] mode_q;
  logic [LEVELS-1:0][1:0] mode_d;
  logic [LEVELS-1:0]      ld_s;

  // Ready chain: a stage may load when it is empty or anything downstream
  // (including the consumer) can move, i.e. r_k = !v_k | r_{k+1}. Written as
  // an OR over the downstream empties so no signal feeds back into itself.
  always_comb begin
    logic acc;
    ld_s = '0;
    acc  = 1'b0;
    for (int k = 0; k < LEVELS; k++) begin
      acc = bus.out_ready;
      for (int m = k; m < LEVELS; m++) begin
        acc = acc | ~v_q[m];
      end
      ld_s[k] = acc;
    end
  end

  // Gather the input words and the registered nodes into one source vector.
  always_comb begin
    for (int n = 0; n < SRCS; n++) begin
      src_s[n] = '0;
    end
    for (int n = 0; n < CHANNELS; n++) begin
      src_s[n] = bus.in_data[n*WIDTH +: WIDTH];
    end
    for (int n = 0; n < NODES - 1; n++) begin
      src_s[CHANNELS + n] = node_q[n];
    end
  end

  // Next node values: combine the two children with the mode of the beat
  // that currently occupies the level feeding this node; hold when stalled.
  always_comb begin
    int         lvl;
    logic [1:0] m;
    lvl = 0;
    m   = 2'b00;
    for (int i = 0; i < NODES; i++) begin
      lvl = node_level(i);
      if (lvl == 0) begin
        m = bus.in_mode;
      end else begin
        m = mode_q[lvl - 1];
      end
      if (ld_s[lvl]) begin
        node_d[i] = combine(src_s[2*i], src_s[2*i+1], m);
      end else begin
        node_d[i] = node_q[i];
      end
    end
  end

  // Next valid flags and modes: a loading stage takes the upstream flag and
  // mode (so bubbles propagate as v=0), a stalled stage keeps its own.
  always_comb begin
    v_d    = v_q;
    mode_d = mode_q;
    if (ld_s[0]) begin
      v_d[0]    = bus.in_valid;
      mode_d[0] = bus.in_mode;
    end else begin
      v_d[0]    = v_q[0];
      mode_d[0] = mode_q[0];
    end
    for (int k = 1; k < LEVELS; k++) begin
      if (ld_s[k]) begin
        v_d[k]    = v_q[k-1];
        mode_d[k] = mode_q[k-1];
      end else begin
        v_d[k]    = v_q[k];
        mode_d[k] = mode_q[k];
      end
    end
  end

  // Stage registers; reset discards every in-flight beat.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      v_q    <= '0;
      mode_q <= '0;
      for (int i = 0; i < NODES; i++) begin
        node_q[i] <= '0;
      end
    end else begin
      v_q    <= v_d;
      mode_q <= mode_d;
      for (int i = 0; i < NODES; i++) begin
        node_q[i] <= node_d[i];
      end
    end
  end

  assign bus.in_ready  = ld_s[0];
  assign bus.out_valid = v_q[LEVELS-1];
  assign bus.out_data  = node_q[NODES-1];
  assign bus.busy      = |v_q;

endmodule
